// File: rtl/pc_gen_pkg.sv
// Shared types for the program-counter generator: FSM states, next-pc source
// encoding and the instruction-alignment mask.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SRC_SEQ  = 2'd0,
      SRC_JUMP = 2'd1,
      SRC_TRAP = 2'd2
   } pc_src_t;

   // Low PC bits that must be zero for a 4-byte aligned instruction address.
   localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

   // Trap outranks a taken jump; otherwise fall through to the sequential PC.
   function automatic pc_src_t sel_src(input logic trap, input logic jump);
      if (trap)
         return SRC_TRAP;
      else if (jump)
         return SRC_JUMP;
      else
         return SRC_SEQ;
   endfunction

endpackage

// File: rtl/pc_hist_buf.sv
// Ring buffer of recent redirect targets; index 0 reads the newest entry and
// any index at or beyond the valid-entry count reads as zero.
module pc_hist_buf #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned HIST_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [XLEN-1:0]               wr_data,
   input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx,
   output logic [XLEN-1:0]               rd_data,
   output logic [$clog2(HIST_DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(HIST_DEPTH);

   logic [XLEN-1:0]  mem [HIST_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + PTR_W'(1);
         if (count != (PTR_W+1)'(HIST_DEPTH))
            count <= count + (PTR_W+1)'(1);
      end
   end

   // Storage is left uncleared by reset; the count gates what is visible.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= wr_data;
   end

   always_comb begin
      rd_addr = wr_ptr - PTR_W'(1) - rd_idx;
      rd_data = '0;
      if ({1'b0, rd_idx} < count)
         rd_data = mem[rd_addr];
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/FETCH/EXEC sequencer with trap > jump > seq
// next-pc selection. Define PC_GEN_HIST_EN to add the redirect-history ring.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_VEC  = 'h8000_0000,
   parameter int unsigned     STEP       = 4,
   parameter int unsigned     HIST_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          fetch_valid,
   input  logic                          fetch_ready,
   output logic [XLEN-1:0]               fetch_pc,
   input  logic                          commit_valid,
   input  logic                          commit_jump,
   input  logic [XLEN-1:0]               commit_target,
   input  logic                          trap_valid,
   input  logic [XLEN-1:0]               trap_target,
   output logic [XLEN-1:0]               pc,
   output logic [XLEN-1:0]               snpc,
`ifdef PC_GEN_HIST_EN
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
   output logic [XLEN-1:0]               hist_data,
   output logic [$clog2(HIST_DEPTH):0]   hist_count,
`endif
   output logic                          misalign
);

   if (HIST_DEPTH < 2 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pc_gen: HIST_DEPTH must be a power of two and at least 2");
   end

   state_t          state;
   pc_src_t         src;
   logic [XLEN-1:0] jump_pc;
   logic [XLEN-1:0] trap_pc;
   logic [XLEN-1:0] next_pc;
   logic            retire;
   logic            jump_misaligned;

   assign snpc     = pc + XLEN'(STEP);
   assign fetch_pc = pc;

   // JALR always drops bit 0; trap vectors are forced fully aligned.
   assign jump_pc = commit_target & ~XLEN'(1'b1);
   assign trap_pc = trap_target & ~XLEN'(PC_ALIGN_MASK);

   assign retire          = (state == EXEC) && (commit_valid || trap_valid);
   assign jump_misaligned = |(jump_pc[1:0] & PC_ALIGN_MASK);

   always_comb begin
      src = sel_src(trap_valid, commit_jump);
      unique case (src)
         SRC_TRAP: next_pc = trap_pc;
         SRC_JUMP: next_pc = jump_pc;
         default:  next_pc = snpc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         pc          <= RESET_VEC;
         fetch_valid <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         misalign <= 1'b0;
         unique case (state)
            BOOT: begin
               state       <= FETCH;
               fetch_valid <= 1'b1;
            end
            FETCH: begin
               if (fetch_ready) begin
                  state       <= EXEC;
                  fetch_valid <= 1'b0;
               end
            end
            EXEC: begin
               if (retire) begin
                  pc          <= next_pc;
                  state       <= FETCH;
                  fetch_valid <= 1'b1;
                  misalign    <= (src == SRC_JUMP) && commit_valid && jump_misaligned;
               end
            end
            default: begin
               state       <= BOOT;
               fetch_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef PC_GEN_HIST_EN
   logic hist_wr;

   assign hist_wr = retire && (trap_valid || commit_jump);

   pc_hist_buf #(
      .XLEN       (XLEN),
      .HIST_DEPTH (HIST_DEPTH)
   ) u_hist (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (hist_wr),
      .wr_data (next_pc),
      .rd_idx  (hist_idx),
      .rd_data (hist_data),
      .count   (hist_count)
   );
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: default instance plus a RESET_VEC=0xFFFF_FFFC
// instance sharing the same stimulus. Hist checks follow PC_GEN_HIST_EN.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_ready;
   logic        commit_valid;
   logic        commit_jump;
   logic [31:0] commit_target;
   logic        trap_valid;
   logic [31:0] trap_target;

   logic        fetch_valid, fetch_valid2;
   logic [31:0] fetch_pc, fetch_pc2;
   logic [31:0] pc, pc2;
   logic [31:0] snpc, snpc2;
   logic        misalign, misalign2;
`ifdef PC_GEN_HIST_EN
   logic [2:0]  hist_idx;
   logic [31:0] hist_data, hist_data2;
   logic [3:0]  hist_count, hist_count2;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_gen #(
      .XLEN       (32),
      .RESET_VEC  (32'h8000_0000),
      .STEP       (4),
      .HIST_DEPTH (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_valid   (fetch_valid),
      .fetch_ready   (fetch_ready),
      .fetch_pc      (fetch_pc),
      .commit_valid  (commit_valid),
      .commit_jump   (commit_jump),
      .commit_target (commit_target),
      .trap_valid    (trap_valid),
      .trap_target   (trap_target),
      .pc            (pc),
      .snpc          (snpc),
`ifdef PC_GEN_HIST_EN
      .hist_idx      (hist_idx),
      .hist_data     (hist_data),
      .hist_count    (hist_count),
`endif
      .misalign      (misalign)
   );

   pc_gen #(
      .XLEN       (32),
      .RESET_VEC  (32'hFFFF_FFFC),
      .STEP       (4),
      .HIST_DEPTH (8)
   ) dut_wrap (
      .clk           (clk),
      .rst           (rst),
      .fetch_valid   (fetch_valid2),
      .fetch_ready   (fetch_ready),
      .fetch_pc      (fetch_pc2),
      .commit_valid  (commit_valid),
      .commit_jump   (commit_jump),
      .commit_target (commit_target),
      .trap_valid    (trap_valid),
      .trap_target   (trap_target),
      .pc            (pc2),
      .snpc          (snpc2),
`ifdef PC_GEN_HIST_EN
      .hist_idx      (hist_idx),
      .hist_data     (hist_data2),
      .hist_count    (hist_count2),
`endif
      .misalign      (misalign2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Outputs settle after the posedge; all driving and sampling happens on negedges.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_commit();
      commit_valid  = 1'b0;
      commit_jump   = 1'b0;
      commit_target = '0;
      trap_valid    = 1'b0;
      trap_target   = '0;
   endtask

   initial begin
      rst         = 1'b1;
      fetch_ready = 1'b0;
      clear_commit();
`ifdef PC_GEN_HIST_EN
      hist_idx = '0;
`endif
      tick();
      tick();

      check("reset_pc",          pc,           32'h8000_0000);
      check("reset_fetch_valid", fetch_valid,  32'd0);
      check("reset_misalign",    misalign,     32'd0);
      check("reset_snpc",        snpc,         32'h8000_0004);
      check("wrap_reset_pc",     pc2,          32'hFFFF_FFFC);
      check("wrap_reset_snpc",   snpc2,        32'h0000_0000);
`ifdef PC_GEN_HIST_EN
      check("reset_hist_count",  hist_count,   32'd0);
`endif

      rst = 1'b0;
      fetch_ready = 1'b1;
      check("boot_bubble", fetch_valid, 32'd0);
      tick();
      check("boot_to_fetch_valid", fetch_valid, 32'd1);
      check("fetch_pc_0",          fetch_pc,    32'h8000_0000);
      tick();
      check("fetch_to_exec_valid", fetch_valid, 32'd0);

      commit_valid = 1'b1;
      tick();
      clear_commit();
      check("fetch_pc_1",       fetch_pc,     32'h8000_0004);
      check("fetch_valid_1",    fetch_valid,  32'd1);
      check("wrap_pc_after",    pc2,          32'h0000_0000);
      check("wrap_misalign",    misalign2,    32'd0);
      check("wrap_snpc_after",  snpc2,        32'h0000_0004);
      tick();
      commit_valid = 1'b1;
      tick();
      clear_commit();
      check("fetch_pc_2",    fetch_pc,    32'h8000_0008);
      check("fetch_valid_2", fetch_valid, 32'd1);

      // Stall in FETCH; a stray commit here is a protocol error and must be ignored.
      fetch_ready  = 1'b0;
      commit_valid = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
         tick();
         check("stall_fetch_valid", fetch_valid, 32'd1);
         check("stall_fetch_pc",    fetch_pc,    32'h8000_0008);
      end
      clear_commit();
      fetch_ready = 1'b1;
      tick();
      check("stall_release_exec", fetch_valid, 32'd0);
      check("stall_release_pc",   pc,          32'h8000_0008);

      commit_valid = 1'b1; commit_jump = 1'b1; commit_target = 32'h8000_0101;
      tick();
      clear_commit();
      check("jump_odd_pc",       pc,       32'h8000_0100);
      check("jump_odd_misalign", misalign, 32'd0);
      tick();

      commit_valid = 1'b1; commit_jump = 1'b1; commit_target = 32'h8000_0102;
      tick();
      clear_commit();
      check("jump_mis_pc",       pc,       32'h8000_0102);
      check("jump_mis_pulse",    misalign, 32'd1);
      check("jump_mis_snpc",     snpc,     32'h8000_0106);
      tick();
      check("jump_mis_pulse_end", misalign, 32'd0);

      commit_valid = 1'b1; commit_jump = 1'b1; commit_target = 32'h8000_0200;
      trap_valid = 1'b1; trap_target = 32'h8000_1000;
      tick();
      clear_commit();
      check("trap_wins_pc",       pc,       32'h8000_1000);
      check("trap_wins_misalign", misalign, 32'd0);
      tick();

      commit_valid = 1'b1; commit_jump = 1'b1; commit_target = 32'h8000_0206;
      trap_valid = 1'b1; trap_target = 32'h8000_2003;
      tick();
      clear_commit();
      check("trap_align_pc",       pc,       32'h8000_2000);
      check("trap_mask_misalign",  misalign, 32'd0);
      tick();

      rst = 1'b1;
      commit_valid = 1'b1;
      tick();
      clear_commit();
      check("mid_rst_pc",          pc,          32'h8000_0000);
      check("mid_rst_fetch_valid", fetch_valid, 32'd0);
`ifdef PC_GEN_HIST_EN
      check("mid_rst_hist_count",  hist_count,  32'd0);
`endif
      rst = 1'b0;
      tick();
      check("mid_rst_boot_fetch",  fetch_valid, 32'd1);
      tick();

      for (int unsigned i = 0; i < 10; i++) begin
         commit_valid  = 1'b1;
         commit_jump   = 1'b1;
         commit_target = 32'h100 + 32'(4 * i);
         tick();
         clear_commit();
         tick();
`ifdef PC_GEN_HIST_EN
         if (i == 2) begin
            hist_idx = 3'd3;
            #1;
            check("hist_beyond_count", hist_data,  32'd0);
            check("hist_count_3",      hist_count, 32'd3);
            hist_idx = 3'd0;
            #1;
            check("hist_newest_3",     hist_data,  32'h108);
         end
`endif
      end
      check("redirect_seq_pc", pc, 32'h124);
`ifdef PC_GEN_HIST_EN
      check("hist_count_sat", hist_count, 32'd8);
      hist_idx = 3'd0;
      #1;
      check("hist_idx0", hist_data, 32'h124);
      hist_idx = 3'd7;
      #1;
      check("hist_idx7", hist_data, 32'h108);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
